fft_strm_frame_sequencer: RTL

Synthesizable frame sequencer that drives a streaming (CFG_ARCH=2) CoreFFT. It waits for twiddle initialisation, issues START pulses gated by RFS, and walks a sample index across each FFT_SIZE-sample input frame. It supports back-to-back or gapped framing, a frame count limit, and a per-frame INVERSE policy. It sits between the input sample source (pattern ROM or capture buffer) and the FFT core, replacing bench-only start generation in hardware test builds.

---
 rtl/fft_seq_pkg.sv | 38 +++
 rtl/fft_seq_ovf_log.sv | 45 ++++
 rtl/fft_strm_frame_sequencer.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/fft_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fft_seq_pkg
// Purpose  : Shared types and constants for the streaming FFT frame sequencer:
//            FSM state encoding, INVERSE policy codes, FRAME_CNT width and a
//            constant ceil_log2 helper used to size the sample index.
// Revision : 1.0 - initial release
// ============================================================================
package fft_seq_pkg;

  localparam int FRAME_CNT_W = 16;

  // INVERSE policy codes
  localparam int INV_MODE_HOLD   = 0;
  localparam int INV_MODE_TOGGLE = 1;
  localparam int INV_MODE_REQ    = 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_INIT = 3'd1,
    ST_WAIT_RFS  = 3'd2,
    ST_LOAD      = 3'd3,
    ST_GAP       = 3'd4,
    ST_DONE      = 3'd5
  } seq_state_t;

  // Smallest r with 2**r >= value; intended for elaboration-time sizing only.
  function automatic int ceil_log2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fft_seq_ovf_log.sv
`default_nettype none
// ============================================================================
// Module   : fft_seq_ovf_log
// Purpose  : Per-frame FFT overflow logger. On every overflow strobe the
//            history shifts left with the current flag entering bit 0, and a
//            sticky flag accumulates any logged overflow. Cleared on run start.
// Revision : 1.0 - initial release
// ============================================================================
module fft_seq_ovf_log #(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             nGrst,
  input  logic             clken,
  input  logic             clr,
  input  logic             ovf_strobe,
  input  logic             ovflow_flag,
  output logic [DEPTH-1:0] ovf_hist,
  output logic             ovf_any
);

  logic [DEPTH-1:0] r_hist;
  logic             r_any;

  // History shift register and sticky overflow flag
  always_ff @(posedge clk or negedge nGrst) begin
    if (!nGrst) begin
      r_hist <= '0;
      r_any  <= 1'b0;
    end else if (clken) begin
      if (clr) begin
        r_hist <= '0;
        r_any  <= 1'b0;
      end else if (ovf_strobe) begin
        r_hist <= DEPTH'({r_hist, ovflow_flag});
        r_any  <= r_any | ovflow_flag;
      end
    end
  end

  assign ovf_hist = r_hist;
  assign ovf_any  = r_any;

endmodule
`default_nettype wire

// File: rtl/fft_strm_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fft_strm_frame_sequencer
// Purpose  : Frame sequencer for a streaming CoreFFT. Waits for twiddle init,
//            issues START gated by RFS, walks the input sample index across
//            each FFT_SIZE-sample frame, supports gapped or back-to-back
//            framing, a frame limit and a per-frame INVERSE policy.
//            Optional overflow logger enabled by macro FFT_SEQ_OVF_LOG_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fft_strm_frame_sequencer
  import fft_seq_pkg::*;
#(
  parameter int FFT_SIZE   = 256,
  parameter int GAP_CLKS   = 0,
  parameter int NUM_FRAMES = 0,
  parameter int INV_MODE   = 0,
  parameter int OVF_DEPTH  = 8
) (
  input  logic                           clk,
  input  logic                           nGrst,
  input  logic                           clken,
  input  logic                           run,
  input  logic                           init_done,
  input  logic                           rfs,
  input  logic                           inv_req,
  input  logic                           ovflow_flag,
  input  logic                           ovf_strobe,
  output logic                           start,
  output logic                           inverse,
  output logic                           sample_valid,
  output logic [ceil_log2(FFT_SIZE)-1:0] sample_idx,
  output logic                           pattern_sel,
  output logic [FRAME_CNT_W-1:0]         frame_cnt,
  output logic                           busy,
  output logic                           done,
  output logic [OVF_DEPTH-1:0]           ovf_hist,
  output logic                           ovf_any
);

  localparam int IW = ceil_log2(FFT_SIZE);
  localparam int GW = (GAP_CLKS > 1) ? ceil_log2(GAP_CLKS) : 1;
  localparam logic [IW-1:0]          IDX_LAST    = IW'(FFT_SIZE - 1);
  localparam logic [GW-1:0]          GAP_LOAD    = GW'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);
  localparam logic [FRAME_CNT_W-1:0] FRAME_LIMIT = FRAME_CNT_W'(NUM_FRAMES);

  seq_state_t             r_state, w_state_nx;
  logic                   r_rfs_seen, w_rfs_seen_nx;
  logic [IW-1:0]          r_idx, w_idx_nx;
  logic [GW-1:0]          r_gap_cnt, w_gap_cnt_nx;
  logic [FRAME_CNT_W-1:0] r_frame_cnt, w_frame_cnt_nx;
  logic                   r_start, w_start_nx;
  logic                   r_valid, w_valid_nx;
  logic                   r_inverse, w_inverse_nx;
  logic                   r_pattern_sel, w_pattern_sel_nx;
  logic                   r_busy, w_busy_nx;
  logic                   r_done, w_done_nx;
  logic                   w_issue;
  logic                   w_run_start;

  // Next-state, counter and output decode; frame issue is shared by
  // WAIT_RFS and the back-to-back path at the end of LOAD.
  always_comb begin
    w_state_nx       = r_state;
    w_rfs_seen_nx    = r_rfs_seen | rfs;
    w_idx_nx         = r_idx;
    w_gap_cnt_nx     = r_gap_cnt;
    w_frame_cnt_nx   = r_frame_cnt;
    w_start_nx       = 1'b0;
    w_valid_nx       = 1'b0;
    w_inverse_nx     = r_inverse;
    w_pattern_sel_nx = r_pattern_sel;
    w_issue          = 1'b0;
    w_run_start      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (run) begin
          w_state_nx       = ST_WAIT_INIT;
          w_frame_cnt_nx   = '0;
          w_pattern_sel_nx = 1'b1;
          w_run_start      = 1'b1;
        end
      end
      ST_WAIT_INIT: begin
        if (!run)           w_state_nx = ST_IDLE;
        else if (init_done) w_state_nx = ST_WAIT_RFS;
      end
      ST_WAIT_RFS: begin
        if (!run)                     w_state_nx = ST_IDLE;
        else if (r_rfs_seen || rfs)   w_issue    = 1'b1;
      end
      ST_LOAD: begin
        if (r_idx == IDX_LAST) begin
          w_idx_nx = '0;
          if ((NUM_FRAMES != 0) && (r_frame_cnt == FRAME_LIMIT)) begin
            w_state_nx = ST_DONE;
          end else if (!run) begin
            w_state_nx = ST_IDLE;
          end else if (GAP_CLKS > 0) begin
            w_state_nx   = ST_GAP;
            w_gap_cnt_nx = GAP_LOAD;
          end else if (r_rfs_seen || rfs) begin
            w_issue = 1'b1;
          end else begin
            w_state_nx = ST_WAIT_RFS;
          end
        end else begin
          w_valid_nx = 1'b1;
          w_idx_nx   = r_idx + IW'(1);
        end
      end
      ST_GAP: begin
        if (r_gap_cnt == '0) w_state_nx   = ST_WAIT_RFS;
        else                 w_gap_cnt_nx = r_gap_cnt - GW'(1);
      end
      ST_DONE: begin
        if (!run) w_state_nx = ST_IDLE;
      end
      default: w_state_nx = ST_IDLE;
    endcase

    // Frame issue: the RFS that triggers START (or arrives with it) is consumed
    if (w_issue) begin
      w_state_nx       = ST_LOAD;
      w_start_nx       = 1'b1;
      w_valid_nx       = 1'b1;
      w_idx_nx         = '0;
      w_rfs_seen_nx    = 1'b0;
      w_frame_cnt_nx   = r_frame_cnt + FRAME_CNT_W'(1);
      w_pattern_sel_nx = r_frame_cnt[0];
      if (INV_MODE == INV_MODE_TOGGLE)   w_inverse_nx = r_frame_cnt[0];
      else if (INV_MODE == INV_MODE_REQ) w_inverse_nx = inv_req;
      else                               w_inverse_nx = 1'b0;
    end

    w_busy_nx = (w_state_nx != ST_IDLE) && (w_state_nx != ST_DONE);
    w_done_nx = (w_state_nx == ST_DONE);
  end

  // State, counters and registered outputs; everything freezes with clken low
  always_ff @(posedge clk or negedge nGrst) begin
    if (!nGrst) begin
      r_state       <= ST_IDLE;
      r_rfs_seen    <= 1'b0;
      r_idx         <= '0;
      r_gap_cnt     <= '0;
      r_frame_cnt   <= '0;
      r_start       <= 1'b0;
      r_valid       <= 1'b0;
      r_inverse     <= 1'b0;
      r_pattern_sel <= 1'b1;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else if (clken) begin
      r_state       <= w_state_nx;
      r_rfs_seen    <= w_rfs_seen_nx;
      r_idx         <= w_idx_nx;
      r_gap_cnt     <= w_gap_cnt_nx;
      r_frame_cnt   <= w_frame_cnt_nx;
      r_start       <= w_start_nx;
      r_valid       <= w_valid_nx;
      r_inverse     <= w_inverse_nx;
      r_pattern_sel <= w_pattern_sel_nx;
      r_busy        <= w_busy_nx;
      r_done        <= w_done_nx;
    end
  end

  assign start        = r_start;
  assign inverse      = r_inverse;
  assign sample_valid = r_valid;
  assign sample_idx   = r_idx;
  assign pattern_sel  = r_pattern_sel;
  assign frame_cnt    = r_frame_cnt;
  assign busy         = r_busy;
  assign done         = r_done;

`ifdef FFT_SEQ_OVF_LOG_EN
  fft_seq_ovf_log #(
    .DEPTH(OVF_DEPTH)
  ) u_ovf_log (
    .clk        (clk),
    .nGrst      (nGrst),
    .clken      (clken),
    .clr        (w_run_start),
    .ovf_strobe (ovf_strobe),
    .ovflow_flag(ovflow_flag),
    .ovf_hist   (ovf_hist),
    .ovf_any    (ovf_any)
  );
`else
  logic w_unused_ovf;
  assign w_unused_ovf = ovflow_flag | ovf_strobe | w_run_start;
  assign ovf_hist     = '0;
  assign ovf_any      = 1'b0;
`endif

endmodule
`default_nettype wire
